dnn2ami_wr_path: RTL and testbench



---
 rtl/dnn2ami_wr_path_pkg.sv | 51 +++++
 rtl/dnn2ami_wr_path_if.sv | 18 +
 rtl/dnn2ami_wr_path_counter64.sv | 16 +
 rtl/dnn2ami_wr_path_fifo.sv | 58 +++++
 rtl/dnn2ami_wr_path.sv | 175 +++++++++++++++++
 tb/tb_dnn2ami_wr_path.sv | 300 ++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/dnn2ami_wr_path_pkg.sv
// -----------------------------------------------------------------------------
// dnn2ami_wr_path_pkg
// Shared constants for the DNN-to-AMI write bridge:
//   - AMI request field layout (valid | isWrite | addr64 | data64 | size64,
//     packed from bit 0 upward) and its total width AMI_REQ_W.
//   - Macro request entry layout (valid | isWrite | addr | size | pu_id | ts);
//     the variable-width fields are located with the helper functions so the
//     top can size them from its own parameters.
//   - Beat size in bytes and the write-path FSM state type.
// -----------------------------------------------------------------------------
package dnn2ami_wr_path_pkg;

    localparam int BEAT_BYTES = 8;

    localparam int AMI_VALID_BIT   = 0;
    localparam int AMI_ISWRITE_BIT = 1;
    localparam int AMI_ADDR_LSB    = 2;
    localparam int AMI_ADDR_W      = 64;
    localparam int AMI_DATA_LSB    = AMI_ADDR_LSB + AMI_ADDR_W;
    localparam int AMI_DATA_W      = 64;
    localparam int AMI_SIZE_LSB    = AMI_DATA_LSB + AMI_DATA_W;
    localparam int AMI_SIZE_W      = 64;
    localparam int AMI_REQ_W       = AMI_SIZE_LSB + AMI_SIZE_W;

    localparam int MACRO_VALID_BIT   = 0;
    localparam int MACRO_ISWRITE_BIT = 1;
    localparam int MACRO_ADDR_LSB    = 2;
    localparam int TS_W              = 64;

    function automatic int macro_size_lsb(int addr_w);
        return MACRO_ADDR_LSB + addr_w;
    endfunction

    function automatic int macro_pu_lsb(int addr_w, int size_w);
        return macro_size_lsb(addr_w) + size_w;
    endfunction

    function automatic int macro_ts_lsb(int addr_w, int size_w, int pu_w);
        return macro_pu_lsb(addr_w, size_w) + pu_w;
    endfunction

    function automatic int macro_w(int addr_w, int size_w, int pu_w);
        return macro_ts_lsb(addr_w, size_w, pu_w) + TS_W;
    endfunction

    typedef enum logic {
        WR_IDLE   = 1'b0,
        WR_ACTIVE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/dnn2ami_wr_path_if.sv
// -----------------------------------------------------------------------------
// dnn2ami_wr_path_if
// AMI request channel between the write bridge and the shared request arbiter.
//   reqValid      head of the bridge's request queue is valid
//   reqOut        head request (AMI_REQ_W bits)
//   reqOut_grant  arbiter accepts the head this cycle
// Modports: master = bridge (drives request), slave = arbiter (drives grant).
// -----------------------------------------------------------------------------
interface dnn2ami_wr_path_if;
    import dnn2ami_wr_path_pkg::*;

    logic                 reqValid;
    logic                 reqOut_grant;
    logic [AMI_REQ_W-1:0] reqOut;

    modport master (output reqValid, output reqOut, input reqOut_grant);
    modport slave  (input reqValid, input reqOut, output reqOut_grant);
endinterface

// File: rtl/dnn2ami_wr_path_counter64.sv
// -----------------------------------------------------------------------------
// dnn2ami_wr_path_counter64
// Free-running 64-bit cycle counter, cleared by reset.
//   clk, rst  clock / asynchronous active-high reset
//   count     current cycle count
// -----------------------------------------------------------------------------
module dnn2ami_wr_path_counter64 (
    input  logic        clk,
    input  logic        rst,
    output logic [63:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else     count <= count + 64'd1;
    end
endmodule

// File: rtl/dnn2ami_wr_path_fifo.sv
// -----------------------------------------------------------------------------
// dnn2ami_wr_path_fifo
// Show-ahead synchronous FIFO of 2**LOG_DEPTH entries.
//   wr_en/wr_data  push (ignored when full unless a pop happens the same cycle)
//   rd_en          pop the head (ignored when empty)
//   rd_data        current head, valid whenever !empty
//   full/empty     occupancy flags
// -----------------------------------------------------------------------------
module dnn2ami_wr_path_fifo #(
    parameter int WIDTH     = 8,
    parameter int LOG_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << LOG_DEPTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr;
    logic [LOG_DEPTH-1:0] rd_ptr;
    logic [LOG_DEPTH:0]   count;
    logic                 do_wr;
    logic                 do_rd;

    assign empty = (count == '0);
    assign full  = (count == (LOG_DEPTH+1)'(DEPTH));
    assign do_rd = rd_en && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/dnn2ami_wr_path.sv
// -----------------------------------------------------------------------------
// dnn2ami_wr_path
// Write-side bridge from DNN output buffers to the AMI request port. Macro
// write requests (PU, base address, beat count) are queued, then fractured
// into 8-byte AMI write requests whose data is popped from the chosen PU's
// output buffer; those requests leave through a valid/grant request queue.
//   clk, rst           clock / asynchronous active-high reset
//   wr_req ... wr_addr macro request strobe and fields
//   outbuf_empty       per-PU output buffer empty
//   data_from_outbuf   PU p data at [(p+1)*AXI_DATA_WIDTH-1 : p*AXI_DATA_WIDTH]
//   write_valid        accepted and ignored
//   outbuf_pop         one-hot combinational pop of the active PU buffer
//   ami                AMI request channel (reqValid / reqOut / reqOut_grant)
//   wr_ready           nothing queued, active or pending
//   wr_done            one-cycle pulse when a macro request retires
// -----------------------------------------------------------------------------
module dnn2ami_wr_path
    import dnn2ami_wr_path_pkg::*;
#(
    parameter int NUM_PU            = 2,
    parameter int AXI_ADDR_WIDTH    = 32,
    parameter int AXI_DATA_WIDTH    = 64,
    parameter int TX_SIZE_WIDTH     = 10,
    parameter int NUM_PU_W          = $clog2(NUM_PU) + 1,
    parameter int MACRO_Q_LOG_DEPTH = 3,
    parameter int REQ_Q_LOG_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_req,
    input  logic [NUM_PU_W-1:0]              wr_pu_id,
    input  logic [TX_SIZE_WIDTH-1:0]         wr_req_size,
    input  logic [AXI_ADDR_WIDTH-1:0]        wr_addr,
    input  logic [NUM_PU-1:0]                outbuf_empty,
    input  logic [NUM_PU*AXI_DATA_WIDTH-1:0] data_from_outbuf,
    input  logic [NUM_PU-1:0]                write_valid,
    output logic [NUM_PU-1:0]                outbuf_pop,
    dnn2ami_wr_path_if.master                ami,
    output logic                             wr_ready,
    output logic                             wr_done
);
    localparam int SIZE_LSB = macro_size_lsb(AXI_ADDR_WIDTH);
    localparam int PU_LSB   = macro_pu_lsb(AXI_ADDR_WIDTH, TX_SIZE_WIDTH);
    localparam int TS_LSB   = macro_ts_lsb(AXI_ADDR_WIDTH, TX_SIZE_WIDTH, NUM_PU_W);
    localparam int MACRO_W  = macro_w(AXI_ADDR_WIDTH, TX_SIZE_WIDTH, NUM_PU_W);

    logic [63:0]               timestamp;
    logic [MACRO_W-1:0]        mq_wdata, mq_rdata;
    logic                      mq_full, mq_empty, mq_rd;
    logic [AMI_REQ_W-1:0]      rq_wdata, rq_rdata;
    logic                      rq_full, rq_empty, rq_rd;

    wr_state_e                 state, state_nxt;
    logic [AXI_ADDR_WIDTH-1:0] address, address_nxt;
    logic [TX_SIZE_WIDTH-1:0]  requests_left, left_nxt;
    logic [NUM_PU_W-1:0]       pu_id, pu_nxt;
    logic                      done_nxt;
    logic                      beat_fire;
    logic                      buf_avail;
    logic [AXI_DATA_WIDTH-1:0] buf_data;
    logic                      unused_bits;

    dnn2ami_wr_path_counter64 u_ts (.clk(clk), .rst(rst), .count(timestamp));

    always_comb begin
        mq_wdata = '0;
        mq_wdata[MACRO_VALID_BIT]                 = wr_req;
        mq_wdata[MACRO_ISWRITE_BIT]               = 1'b1;
        mq_wdata[MACRO_ADDR_LSB +: AXI_ADDR_WIDTH] = wr_addr;
        mq_wdata[SIZE_LSB +: TX_SIZE_WIDTH]       = wr_req_size;
        mq_wdata[PU_LSB +: NUM_PU_W]              = wr_pu_id;
        mq_wdata[TS_LSB +: TS_W]                  = timestamp;
    end

    dnn2ami_wr_path_fifo #(.WIDTH(MACRO_W), .LOG_DEPTH(MACRO_Q_LOG_DEPTH)) u_macro_q (
        .clk(clk), .rst(rst),
        .wr_en(wr_req && !mq_full), .wr_data(mq_wdata),
        .rd_en(mq_rd), .rd_data(mq_rdata),
        .full(mq_full), .empty(mq_empty)
    );

    // Buffer of the active PU. An out-of-range PU id never reports data, so
    // such a macro stalls rather than reading a nonexistent buffer.
    always_comb begin
        buf_avail  = 1'b0;
        buf_data   = '0;
        outbuf_pop = '0;
        for (int p = 0; p < NUM_PU; p++) begin
            if (int'(pu_id) == p) begin
                buf_avail     = !outbuf_empty[p];
                buf_data      = data_from_outbuf[p*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                outbuf_pop[p] = beat_fire;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WR_IDLE;
            address       <= '0;
            requests_left <= '0;
            pu_id         <= '0;
            wr_done       <= 1'b0;
        end else begin
            state         <= state_nxt;
            address       <= address_nxt;
            requests_left <= left_nxt;
            pu_id         <= pu_nxt;
            wr_done       <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        address_nxt = address;
        left_nxt    = requests_left;
        pu_nxt      = pu_id;
        done_nxt    = 1'b0;
        mq_rd       = 1'b0;
        beat_fire   = 1'b0;
        case (state)
            WR_IDLE: begin
                if (!mq_empty) begin
                    mq_rd       = 1'b1;
                    address_nxt = mq_rdata[MACRO_ADDR_LSB +: AXI_ADDR_WIDTH];
                    left_nxt    = mq_rdata[SIZE_LSB +: TX_SIZE_WIDTH];
                    pu_nxt      = mq_rdata[PU_LSB +: NUM_PU_W];
                    state_nxt   = WR_ACTIVE;
                end
            end
            WR_ACTIVE: begin
                if (requests_left == '0) begin
                    // Zero-beat macro retires without touching any buffer.
                    done_nxt  = 1'b1;
                    state_nxt = WR_IDLE;
                end else if (buf_avail && !rq_full) begin
                    beat_fire   = 1'b1;
                    address_nxt = address + AXI_ADDR_WIDTH'(BEAT_BYTES);
                    left_nxt    = requests_left - 1'b1;
                    if (requests_left == TX_SIZE_WIDTH'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = WR_IDLE;
                    end
                end
            end
            default: state_nxt = WR_IDLE;
        endcase
    end

    always_comb begin
        rq_wdata = '0;
        rq_wdata[AMI_VALID_BIT]               = 1'b1;
        rq_wdata[AMI_ISWRITE_BIT]             = 1'b1;
        rq_wdata[AMI_ADDR_LSB +: AMI_ADDR_W]  = AMI_ADDR_W'(address);
        rq_wdata[AMI_DATA_LSB +: AMI_DATA_W]  = AMI_DATA_W'(buf_data);
        rq_wdata[AMI_SIZE_LSB +: AMI_SIZE_W]  = AMI_SIZE_W'(BEAT_BYTES);
    end

    dnn2ami_wr_path_fifo #(.WIDTH(AMI_REQ_W), .LOG_DEPTH(REQ_Q_LOG_DEPTH)) u_req_q (
        .clk(clk), .rst(rst),
        .wr_en(beat_fire), .wr_data(rq_wdata),
        .rd_en(rq_rd), .rd_data(rq_rdata),
        .full(rq_full), .empty(rq_empty)
    );

    assign ami.reqValid = !rq_empty && rq_rdata[AMI_VALID_BIT];
    assign ami.reqOut   = rq_rdata;
    assign rq_rd        = ami.reqValid && ami.reqOut_grant;

    assign wr_ready = mq_empty && (state == WR_IDLE) && rq_empty;

    // Timestamp and entry flags are carried for debug visibility only.
    assign unused_bits = ^{write_valid, mq_rdata[MACRO_VALID_BIT],
                           mq_rdata[MACRO_ISWRITE_BIT], mq_rdata[TS_LSB +: TS_W]};
endmodule

// File: tb/tb_dnn2ami_wr_path.sv
// -----------------------------------------------------------------------------
// tb_dnn2ami_wr_path
// Self-checking bench for dnn2ami_wr_path. Each PU output buffer is modelled
// as an endless word stream; the expected AMI request list is built when a
// macro is issued (address base+8k, next word of that PU's stream).
// -----------------------------------------------------------------------------
module tb_dnn2ami_wr_path;
    import dnn2ami_wr_path_pkg::*;

    localparam int NUM_PU = 2;
    localparam int AW     = 32;
    localparam int DW     = 64;
    localparam int SW     = 10;
    localparam int PW     = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 wr_req;
    logic [PW-1:0]        wr_pu_id;
    logic [SW-1:0]        wr_req_size;
    logic [AW-1:0]        wr_addr;
    logic [NUM_PU-1:0]    outbuf_empty;
    logic [NUM_PU-1:0]    write_valid;
    logic [NUM_PU-1:0]    outbuf_pop;
    logic [NUM_PU*DW-1:0] data_from_outbuf;
    logic                 wr_ready;
    logic                 wr_done;

    logic                 grant, grant_force, rnd_grant, rnd_empty;
    logic [NUM_PU-1:0]    hold_empty, empty_force;

    dnn2ami_wr_path_if ami();

    assign ami.reqOut_grant = grant;
    assign outbuf_empty     = hold_empty;
    assign write_valid      = '0;

    dnn2ami_wr_path #(
        .NUM_PU(NUM_PU), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .TX_SIZE_WIDTH(SW), .NUM_PU_W(PW),
        .MACRO_Q_LOG_DEPTH(3), .REQ_Q_LOG_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_pu_id(wr_pu_id), .wr_req_size(wr_req_size), .wr_addr(wr_addr),
        .outbuf_empty(outbuf_empty), .data_from_outbuf(data_from_outbuf),
        .write_valid(write_valid), .outbuf_pop(outbuf_pop),
        .ami(ami), .wr_ready(wr_ready), .wr_done(wr_done)
    );

    // Word n of PU p's output stream.
    function automatic logic [63:0] word(int p, int n);
        return (64'(p + 1) << 56) ^ (64'(n) * 64'h9E37_79B9_7F4A_7C15);
    endfunction

    int popcnt [NUM_PU];
    always @(posedge clk) begin
        for (int p = 0; p < NUM_PU; p++)
            if (outbuf_pop[p]) popcnt[p] <= popcnt[p] + 1;
    end

    always_comb begin
        data_from_outbuf = '0;
        for (int p = 0; p < NUM_PU; p++)
            data_from_outbuf[p*DW +: DW] = word(p, popcnt[p]);
    end

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        string       name;
        int          pu;
        logic [31:0] addr;
        int          size;
        bit          r_empty;
        bit          r_grant;
        int          exp_beats;
        int          exp_done;
    } vec_t;

    exp_t exp_q [$];
    int   model_idx [NUM_PU];
    int   n_checks, n_fail, n_beats, n_done, n_pops;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(int pu, logic [31:0] addr, int size);
        logic [31:0] a;
        exp_t        e;
        a = addr;
        for (int k = 0; k < size; k++) begin
            e.addr = {32'b0, a};
            e.data = word(pu, model_idx[pu]);
            exp_q.push_back(e);
            model_idx[pu]++;
            a = a + 32'd8;
        end
        wr_req      = 1'b1;
        wr_pu_id    = PW'(pu);
        wr_req_size = SW'(size);
        wr_addr     = addr;
        step();
        wr_req      = 1'b0;
    endtask

    task automatic wait_idle(string name, int budget);
        int c;
        c = 0;
        while (!(wr_ready && exp_q.size() == 0) && c < budget) begin
            step();
            c++;
        end
        step(2);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_ready"}, 64'(wr_ready), 64'd1);
    endtask

    task automatic set_mode(bit re, bit rg, logic [NUM_PU-1:0] ef, logic gf);
        rnd_empty   = re;
        rnd_grant   = rg;
        empty_force = ef;
        grant_force = gf;
        step(2);
    endtask

    task automatic check_idle_outputs(string name);
        chk({name, "_ready"}, 64'(wr_ready), 64'd1);
        chk({name, "_reqValid"}, 64'(ami.reqValid), 64'd0);
        chk({name, "_done"}, 64'(wr_done), 64'd0);
        chk({name, "_pop"}, 64'(outbuf_pop), 64'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   b0, d0, p0, tot, nm, sz;

        rst = 1'b1;
        wr_req = 1'b0; wr_pu_id = '0; wr_req_size = '0; wr_addr = '0;
        grant = 1'b0; hold_empty = '0;
        rnd_grant = 1'b0; rnd_empty = 1'b0; grant_force = 1'b1; empty_force = '0;

        fork
            // Input driver: grant and buffer-empty flags change 2 units after each edge.
            forever begin
                @(posedge clk);
                #2;
                grant      = rnd_grant ? 1'($urandom_range(0, 1)) : grant_force;
                hold_empty = rnd_empty ? NUM_PU'($urandom) : empty_force;
            end
            // Monitor: pops, done pulses and accepted requests, mid-cycle.
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (outbuf_pop != '0) begin
                        n_pops += $countones(outbuf_pop);
                        chk("pop_onehot", 64'($countones(outbuf_pop)), 64'd1);
                        chk("pop_when_empty", 64'(outbuf_pop & hold_empty), 64'd0);
                    end
                    if (wr_done) n_done++;
                    if (ami.reqValid && grant) begin
                        n_beats++;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_req", 64'd1, 64'd0);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("req_addr", ami.reqOut[AMI_ADDR_LSB +: 64], e.addr);
                            chk("req_data", ami.reqOut[AMI_DATA_LSB +: 64], e.data);
                            chk("req_size", ami.reqOut[AMI_SIZE_LSB +: 64], 64'd8);
                            chk("req_flags", 64'(ami.reqOut[1:0]), 64'd3);
                        end
                    end
                end
            end
        join_none

        // Reset and idle
        step(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        step(2);
        check_idle_outputs("idle");

        // Exact timing of a 4-beat macro on PU1 with data always present
        set_mode(1'b0, 1'b0, 2'b00, 1'b1);
        d0 = n_done;
        issue(1, 32'h1000, 4);
        chk("t_n1_pop", 64'(outbuf_pop), 64'd0);
        chk("t_n1_reqValid", 64'(ami.reqValid), 64'd0);
        step();
        chk("t_n2_pop", 64'(outbuf_pop), 64'b10);
        step();
        chk("t_n3_pop", 64'(outbuf_pop), 64'b10);
        chk("t_n3_reqValid", 64'(ami.reqValid), 64'd1);
        step();
        chk("t_n4_pop", 64'(outbuf_pop), 64'b10);
        step();
        chk("t_n5_pop", 64'(outbuf_pop), 64'b10);
        chk("t_n5_done", 64'(wr_done), 64'd0);
        step();
        chk("t_n6_pop", 64'(outbuf_pop), 64'd0);
        chk("t_n6_done", 64'(wr_done), 64'd1);
        chk("t_n6_ready", 64'(wr_ready), 64'd0);
        step();
        chk("t_n7_done", 64'(wr_done), 64'd0);
        chk("t_n7_ready", 64'(wr_ready), 64'd1);
        chk("t_done_count", 64'(n_done - d0), 64'd1);

        // Table-driven macros
        vecs[0] = '{"pu1_plain",   1, 32'h0000_1000, 4,  1'b0, 1'b0, 4,  1};
        vecs[1] = '{"pu1_toggle",  1, 32'h0000_1000, 4,  1'b1, 1'b0, 4,  1};
        vecs[2] = '{"pu0_grant",   0, 32'h0000_2000, 7,  1'b0, 1'b1, 7,  1};
        vecs[3] = '{"addr_wrap",   0, 32'hFFFF_FFF0, 4,  1'b1, 1'b1, 4,  1};
        vecs[4] = '{"size_zero",   1, 32'h0000_0040, 0,  1'b0, 1'b0, 0,  1};
        vecs[5] = '{"odd_addr",    1, 32'h0000_0123, 17, 1'b1, 1'b1, 17, 1};
        for (int i = 0; i < 6; i++) begin
            set_mode(vecs[i].r_empty, vecs[i].r_grant, 2'b00, 1'b1);
            b0 = n_beats; d0 = n_done; p0 = n_pops;
            issue(vecs[i].pu, vecs[i].addr, vecs[i].size);
            wait_idle(vecs[i].name, 600);
            chk({vecs[i].name, "_beats"}, 64'(n_beats - b0), 64'(vecs[i].exp_beats));
            chk({vecs[i].name, "_pops"}, 64'(n_pops - p0), 64'(vecs[i].exp_beats));
            chk({vecs[i].name, "_dones"}, 64'(n_done - d0), 64'(vecs[i].exp_done));
        end

        // Request queue backpressure: 20 beats against a 16-entry queue
        set_mode(1'b0, 1'b0, 2'b00, 1'b0);
        b0 = n_beats; d0 = n_done; p0 = n_pops;
        issue(0, 32'h0000_8000, 20);
        step(40);
        chk("bp_pops_stalled", 64'(n_pops - p0), 64'd16);
        chk("bp_reqValid", 64'(ami.reqValid), 64'd1);
        chk("bp_no_done", 64'(n_done - d0), 64'd0);
        set_mode(1'b0, 1'b0, 2'b00, 1'b1);
        wait_idle("bp", 200);
        chk("bp_beats", 64'(n_beats - b0), 64'd20);
        chk("bp_dones", 64'(n_done - d0), 64'd1);

        // Randomized bursts of back-to-back macros
        for (int r = 0; r < 8; r++) begin
            set_mode(1'b1, 1'b1, 2'b00, 1'b1);
            b0 = n_beats; d0 = n_done;
            nm = $urandom_range(1, 3);
            tot = 0;
            for (int m = 0; m < nm; m++) begin
                sz = $urandom_range(0, 24);
                tot += sz;
                issue($urandom_range(0, NUM_PU - 1), $urandom, sz);
            end
            wait_idle("rand", 3000);
            chk("rand_beats", 64'(n_beats - b0), 64'(tot));
            chk("rand_dones", 64'(n_done - d0), 64'(nm));
        end

        // Reset in the middle of a macro discards everything in flight
        set_mode(1'b0, 1'b0, 2'b00, 1'b0);
        issue(1, 32'h0000_3000, 10);
        step(5);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        exp_q.delete();
        for (int p = 0; p < NUM_PU; p++) model_idx[p] = popcnt[p];
        step(2);
        rst = 1'b0;
        set_mode(1'b0, 1'b0, 2'b00, 1'b1);
        b0 = n_beats; d0 = n_done;
        issue(0, 32'h0000_4000, 3);
        wait_idle("postrst", 200);
        chk("postrst_beats", 64'(n_beats - b0), 64'd3);
        chk("postrst_dones", 64'(n_done - d0), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
